// File: rtl/fir_mac_scheduler_if.sv
// Control bundle between the decimating-FIR sequencer, its input/output FIFOs
// and the shared MAC datapath (addresses and enables only, no data).
interface fir_mac_scheduler_if #(
  parameter int ADDR_W = 5
);
  logic              x_empty;
  logic              x_rd_en;
  logic              smp_we;
  logic              smp_zero;
  logic [ADDR_W-1:0] smp_waddr;
  logic [ADDR_W-1:0] smp_raddr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_en;
  logic              mac_clr;
  logic              y_out_full;
  logic              y_wr_en;
  logic              busy;

  modport master (
    input  x_empty, y_out_full,
    output x_rd_en, smp_we, smp_zero, smp_waddr, smp_raddr, coef_addr,
           mac_en, mac_clr, y_wr_en, busy
  );

  modport slave (
    output x_empty, y_out_full,
    input  x_rd_en, smp_we, smp_zero, smp_waddr, smp_raddr, coef_addr,
           mac_en, mac_clr, y_wr_en, busy
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Sequencer for a time-multiplexed decimating FIR: buffer clear, sample load,
// tap iteration, MAC drain and output push. Define FIR_SCHED_STATS_EN for stall/starve counters.
module fir_mac_scheduler #(
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int MAC_LAT    = 2,
  parameter int ADDR_W     = $clog2(TAPS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fir_mac_scheduler_if.master bus,
  output logic [31:0]         o_stall_cycles,
  output logic [31:0]         o_starve_cycles
);

  localparam int DC_W = $clog2(DECIMATION + 1);
  localparam int DL_W = $clog2(MAC_LAT + 1);

  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   TAPS_X   = (ADDR_W + 1)'(TAPS);
  localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W + 1)'(1);
  localparam logic [DC_W-1:0]   LAST_D   = DC_W'(DECIMATION - 1);
  localparam logic [DC_W-1:0]   ONE_D    = DC_W'(1);
  localparam logic [DL_W-1:0]   LAST_DLY = DL_W'(MAC_LAT - 1);
  localparam logic [DL_W-1:0]   ONE_DLY  = DL_W'(1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_wptr, w_wptr_next;
  logic [ADDR_W-1:0] r_k, w_k_next;
  logic [DC_W-1:0]   r_dcnt, w_dcnt_next;
  logic [DL_W-1:0]   r_dly, w_dly_next;

  logic              w_x_rd_en, w_smp_we, w_smp_zero;
  logic [ADDR_W-1:0] w_waddr, w_raddr, w_coef;
  logic              w_mac_en, w_mac_clr, w_y_wr_en, w_busy;

  // Newest-first tap address; a negative difference wraps by adding TAPS
  // so a non-power-of-two buffer never sees an out-of-range address.
  logic [ADDR_W:0]   w_tap_diff, w_tap_wrap;
  assign w_tap_diff = {1'b0, r_wptr} - {1'b0, r_k} - ONE_X;
  assign w_tap_wrap = w_tap_diff[ADDR_W] ? (w_tap_diff + TAPS_X) : w_tap_diff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_wptr  <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
      r_dly   <= '0;
    end else begin
      r_state <= w_state_next;
      r_wptr  <= w_wptr_next;
      r_k     <= w_k_next;
      r_dcnt  <= w_dcnt_next;
      r_dly   <= w_dly_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wptr_next  = r_wptr;
    w_k_next     = r_k;
    w_dcnt_next  = r_dcnt;
    w_dly_next   = r_dly;
    w_x_rd_en    = 1'b0;
    w_smp_we     = 1'b0;
    w_smp_zero   = 1'b0;
    w_waddr      = '0;
    w_raddr      = '0;
    w_coef       = '0;
    w_mac_en     = 1'b0;
    w_mac_clr    = 1'b0;
    w_y_wr_en    = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        w_smp_we   = 1'b1;
        w_smp_zero = 1'b1;
        w_waddr    = r_k;
        if (r_k == LAST_K) begin
          w_k_next     = '0;
          w_state_next = ST_LOAD;
        end else begin
          w_k_next = r_k + ONE_A;
        end
      end
      ST_LOAD: begin
        w_busy    = 1'b0;
        w_x_rd_en = !bus.x_empty;
        w_smp_we  = !bus.x_empty;
        w_waddr   = r_wptr;
        if (!bus.x_empty) begin
          w_wptr_next = (r_wptr == LAST_K) ? '0 : (r_wptr + ONE_A);
          if (r_dcnt == LAST_D) begin
            w_dcnt_next  = '0;
            w_state_next = ST_MAC;
          end else begin
            w_dcnt_next = r_dcnt + ONE_D;
          end
        end
      end
      ST_MAC: begin
        w_mac_en  = 1'b1;
        w_mac_clr = (r_k == '0);
        w_coef    = r_k;
        w_raddr   = w_tap_wrap[ADDR_W-1:0];
        if (r_k == LAST_K) begin
          w_k_next     = '0;
          w_dly_next   = '0;
          w_state_next = ST_DRAIN;
        end else begin
          w_k_next = r_k + ONE_A;
        end
      end
      ST_DRAIN: begin
        if (r_dly == LAST_DLY) begin
          w_dly_next   = '0;
          w_state_next = ST_OUT;
        end else begin
          w_dly_next = r_dly + ONE_DLY;
        end
      end
      ST_OUT: begin
        w_y_wr_en = !bus.y_out_full;
        if (!bus.y_out_full) begin
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  // Outputs are forced low while reset is held, without waiting for a clock.
  assign bus.x_rd_en   = i_rst_n & w_x_rd_en;
  assign bus.smp_we    = i_rst_n & w_smp_we;
  assign bus.smp_zero  = i_rst_n & w_smp_zero;
  assign bus.smp_waddr = i_rst_n ? w_waddr : '0;
  assign bus.smp_raddr = i_rst_n ? w_raddr : '0;
  assign bus.coef_addr = i_rst_n ? w_coef : '0;
  assign bus.mac_en    = i_rst_n & w_mac_en;
  assign bus.mac_clr   = i_rst_n & w_mac_clr;
  assign bus.y_wr_en   = i_rst_n & w_y_wr_en;
  assign bus.busy      = i_rst_n & w_busy;

`ifdef FIR_SCHED_STATS_EN
  logic [31:0] r_stall_cycles, r_starve_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles  <= '0;
      r_starve_cycles <= '0;
    end else begin
      if (r_state == ST_OUT && bus.y_out_full && r_stall_cycles != 32'hffff_ffff) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (r_state == ST_LOAD && bus.x_empty && r_starve_cycles != 32'hffff_ffff) begin
        r_starve_cycles <= r_starve_cycles + 32'd1;
      end
    end
  end

  assign o_stall_cycles  = r_stall_cycles;
  assign o_starve_cycles = r_starve_cycles;
`else
  assign o_stall_cycles  = 32'd0;
  assign o_starve_cycles = 32'd0;
`endif

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Sequencing controller for a time-multiplexed decimating FIR: one shared multiply-accumulate (MAC) unit, one sample RAM and one coefficient ROM.
- Sits between the input FIFO (first-word-fall-through), the datapath and the output FIFO.
- Manages the circular sample buffer, decimation counting, tap iteration, MAC pipeline drain and the output write handshake.
- Holds no data path of its own: it drives addresses and enables only.

Parameters:
TAPS, 32, filter length; number of MAC cycles per output; must be >= 2
DECIMATION, 8, input samples accepted per output produced; must be >= 1
MAC_LAT, 2, cycles from last mac_en to the result being valid at the accumulator output; must be >= 1
ADDR_W, $clog2(TAPS), width of sample and coefficient addresses

Ports:
clock  in  1  single clock domain, rising edge
reset  in  1  asynchronous, active-low reset
x_empty  in  1  input FIFO empty
x_rd_en  out  1  input FIFO pop; FIFO dout valid in the same cycle
smp_we  out  1  sample RAM write enable
smp_zero  out  1  selects 0 instead of x_in as RAM write data (buffer clear)
smp_waddr  out  ADDR_W  sample RAM write address
smp_raddr  out  ADDR_W  sample RAM read address (synchronous read)
coef_addr  out  ADDR_W  coefficient ROM address
mac_en  out  1  MAC operand valid for this tap
mac_clr  out  1  with mac_en: load product instead of accumulate (tap 0)
y_out_full  in  1  output FIFO full
y_wr_en  out  1  output FIFO push of accumulator result
busy  out  1  high in every state except LOAD

Behaviour:
- Reset: async, on reset==0 all outputs go to 0, state=CLEAR, wptr=0, dcnt=0, k=0.
- CLEAR: smp_we=1, smp_zero=1, smp_waddr=k, for k=0..TAPS-1 (TAPS cycles); x_rd_en=0. Then k=0 and state=LOAD.
- LOAD: x_rd_en = smp_we = !x_empty; smp_waddr=wptr, smp_zero=0.
  - On each pop: wptr=(wptr+1) mod TAPS (explicit wrap; TAPS need not be a power of 2) and dcnt++.
  - When the pop makes dcnt==DECIMATION: dcnt=0, state=MAC.
  - x_empty stalls with no pop and no state change.
- MAC: one tap per cycle for k=0..TAPS-1.
  - smp_raddr=(wptr-1-k) mod TAPS (newest sample first), coef_addr=k, mac_en=1, mac_clr=(k==0).
  - After k=TAPS-1: state=DRAIN, counter=0.
  - x_rd_en=0 throughout.
- DRAIN: all enables 0 for MAC_LAT cycles, then state=OUT.
- OUT: y_wr_en = !y_out_full, for exactly one cycle, then state=LOAD.
  - y_out_full holds the state with y_wr_en=0; no limit on the wait.
- Throughput: DECIMATION + TAPS + MAC_LAT + 1 cycles per output when the input is never empty and the output never full.
  - First pop is the cycle after CLEAR completes.
- Simultaneous events: y_out_full rising on the y_wr_en cycle has no effect; y_wr_en is decided combinationally from the same-cycle y_out_full.
- Reset mid-operation: any partial decimation or MAC sequence is abandoned.
  - CLEAR re-runs; no y_wr_en is issued for the abandoned output.
- Address arithmetic: done at ADDR_W+1 bits, adding TAPS when negative; no out-of-range address is ever driven.

Optional Feature:
- Macro FIR_SCHED_STATS_EN.
- When defined:
  - Adds output stall_cycles (32 bits), counting cycles spent in OUT with y_out_full=1, saturating at 32'hffffffff.
  - Adds output starve_cycles (32 bits), counting LOAD cycles with x_empty=1, saturating likewise.
  - Both counters clear on reset.
- When undefined:
  - Both ports still exist and are tied to 0; no counter logic is generated.

Test Plan:
1. Reset with TAPS=4, DECIMATION=2, MAC_LAT=2.
   -> After release: 4 CLEAR cycles with smp_we=1, smp_zero=1, waddr 0,1,2,3, and busy=1; then busy=0.
2. Push samples 1,2 into an always-ready FIFO, output never full.
   -> Pops write waddr 0,1.
   -> MAC raddr sequence 1,0,3,2 with coef_addr 0,1,2,3; mac_clr only on the first.
   -> 2 drain cycles, then a single y_wr_en.
   -> 9 cycles from first pop to y_wr_en.
3. Continuous stream of 8 samples.
   -> Writes wrap waddr 0,1,2,3,0,1,2,3.
   -> Fourth MAC burst raddr 3,2,1,0.
   -> Exactly 4 y_wr_en pulses.
4. Hold y_out_full=1 for 5 cycles on reaching OUT.
   -> y_wr_en stays 0, state is held, x_rd_en=0.
   -> y_wr_en pulses on the cycle y_out_full drops.
   -> With FIR_SCHED_STATS_EN, stall_cycles=5.
5. Deassert x_empty for 1 sample, then make it empty for 3 cycles.
   -> dcnt is held and no MAC starts.
   -> With FIR_SCHED_STATS_EN, starve_cycles=3.
6. Assert reset during MAC tap k=2.
   -> All outputs are 0 immediately (async).
   -> CLEAR re-runs and waddr restarts at 0.
   -> No y_wr_en for the interrupted output.
